// File: rtl/mc_control_fsm_pkg.sv
// rtl/mc_control_fsm_pkg.sv - shared state, encoding and opcode definitions for the multi-cycle sequencer
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_PC4    = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

  localparam logic [1:0] ALUB_REG  = 2'd0;
  localparam logic [1:0] ALUB_IMM  = 2'd1;
  localparam logic [1:0] ALUB_FOUR = 2'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_BR    = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [6:0] OP_LOAD           = 7'b0000011;
  localparam logic [6:0] OP_STORE          = 7'b0100011;
  localparam logic [6:0] OP_BRANCH         = 7'b1100011;
  localparam logic [6:0] OP_JAL            = 7'b1101111;
  localparam logic [6:0] OP_JALR           = 7'b1100111;
  localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
  localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
  localparam logic [6:0] OP_ECALL          = 7'b1110011;

  // One bundle of every control output, so reset gating is a single assignment.
  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '0;

  function automatic logic needs_ex(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BRANCH) ||
           (op == OP_JAL) || (op == OP_JALR) || (op == OP_ARITHMETIC) ||
           (op == OP_ARITHMETIC_IMM);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - datapath-facing control bundle between sequencer (master) and datapath (slave)
interface mc_ctrl_if #(
  parameter int INST_W = 32
);
  logic [INST_W-1:0] inst;
  logic              mem_ready;
  logic              bcond;
  logic              halt_req;
  logic              pc_write;
  logic [1:0]        pc_source;
  logic              i_or_d;
  logic              mem_read;
  logic              mem_write;
  logic              ir_write;
  logic              reg_write;
  logic [1:0]        wb_sel;
  logic              alu_src_a;
  logic [1:0]        alu_src_b;
  logic [1:0]        alu_op;
  logic              halted;
  logic [31:0]       cycle_count;
  logic [31:0]       instret_count;

  modport master (
    input  inst, mem_ready, bcond, halt_req,
    output pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
           reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, halted,
           cycle_count, instret_count
  );

  modport slave (
    output inst, mem_ready, bcond, halt_req,
    input  pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
           reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, halted,
           cycle_count, instret_count
  );
endinterface

// File: rtl/mc_control_fsm_perf_counters.sv
// rtl/mc_control_fsm_perf_counters.sv - free-running cycle and retired-instruction counters
module mc_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        cycle_en,
  input  logic        instret_en,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  logic [31:0] cycle_q;
  logic [31:0] instret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (cycle_en)   cycle_q   <= cycle_q + 32'd1;
      if (instret_en) instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - RV32I multi-cycle sequencer (IF/ID/EX/MEM/WB/HALT)
// Optional performance counters are built when MC_CTRL_PERF_CNT_EN is defined.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int INST_W = 32
) (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);

  localparam int OPC_MSB = (INST_W > 7) ? 6 : INST_W - 1;

  state_e     state_q;
  state_e     state_d;
  ctl_t       ctl;
  ctl_t       ctl_out;
  logic [6:0] opcode;

  assign opcode = 7'(bus.inst[OPC_MSB:0]);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctl     = CTL_IDLE;
    unique case (state_q)
      S_IF: begin
        ctl.mem_read = 1'b1;
        ctl.ir_write = bus.mem_ready;
        if (bus.mem_ready) state_d = S_ID;
      end
      S_ID: begin
        // ALUOut latches PC+imm here for branch/JAL targets in EX.
        ctl.alu_src_a = 1'b0;
        ctl.alu_src_b = ALUB_IMM;
        ctl.alu_op    = ALUOP_ADD;
        if (opcode == OP_ECALL && bus.halt_req) begin
          state_d = S_HALT;
        end else if (opcode == OP_ECALL || !needs_ex(opcode)) begin
          ctl.pc_write  = 1'b1;
          ctl.pc_source = PC_SRC_PC4;
          state_d       = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        state_d = S_IF;
        case (opcode)
          OP_ARITHMETIC, OP_ARITHMETIC_IMM: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = (opcode == OP_ARITHMETIC) ? ALUB_REG : ALUB_IMM;
            ctl.alu_op    = ALUOP_FUNCT;
            state_d       = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = ALUB_IMM;
            ctl.alu_op    = ALUOP_ADD;
            state_d       = S_MEM;
          end
          OP_BRANCH: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = ALUB_REG;
            ctl.alu_op    = ALUOP_BR;
            ctl.pc_write  = 1'b1;
            ctl.pc_source = bus.bcond ? PC_SRC_ALUOUT : PC_SRC_PC4;
          end
          OP_JAL: begin
            ctl.reg_write = 1'b1;
            ctl.wb_sel    = WB_PC4;
            ctl.pc_write  = 1'b1;
            ctl.pc_source = PC_SRC_ALUOUT;
          end
          OP_JALR: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = ALUB_IMM;
            ctl.alu_op    = ALUOP_ADD;
            ctl.reg_write = 1'b1;
            ctl.wb_sel    = WB_PC4;
            ctl.pc_write  = 1'b1;
            ctl.pc_source = PC_SRC_ALU;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        ctl.i_or_d    = 1'b1;
        ctl.mem_read  = (opcode == OP_LOAD);
        ctl.mem_write = (opcode == OP_STORE);
        if (bus.mem_ready) begin
          if (opcode == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            ctl.pc_write  = 1'b1;
            ctl.pc_source = PC_SRC_PC4;
            state_d       = S_IF;
          end
        end
      end
      S_WB: begin
        ctl.reg_write = 1'b1;
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PC_SRC_PC4;
        ctl.wb_sel    = (opcode == OP_LOAD) ? WB_MDR : WB_ALUOUT;
        state_d       = S_IF;
      end
      S_HALT: begin
        ctl.halted = 1'b1;
      end
      default: state_d = S_IF;
    endcase
    if (reset) state_d = S_IF;
  end

  // A reset cycle looks like an idle fetch so no write escapes while the old state is still held.
  always_comb begin
    ctl_out = ctl;
    if (reset) begin
      ctl_out          = CTL_IDLE;
      ctl_out.mem_read = 1'b1;
    end
  end

  assign bus.pc_write  = ctl_out.pc_write;
  assign bus.pc_source = ctl_out.pc_source;
  assign bus.i_or_d    = ctl_out.i_or_d;
  assign bus.mem_read  = ctl_out.mem_read;
  assign bus.mem_write = ctl_out.mem_write;
  assign bus.ir_write  = ctl_out.ir_write;
  assign bus.reg_write = ctl_out.reg_write;
  assign bus.wb_sel    = ctl_out.wb_sel;
  assign bus.alu_src_a = ctl_out.alu_src_a;
  assign bus.alu_src_b = ctl_out.alu_src_b;
  assign bus.alu_op    = ctl_out.alu_op;
  assign bus.halted    = ctl_out.halted;

`ifdef MC_CTRL_PERF_CNT_EN
  logic cycle_en;
  logic instret_en;

  assign cycle_en   = (state_q != S_HALT);
  assign instret_en = (state_d == S_IF) || (state_d == S_HALT);

  mc_perf_counters u_perf (
    .clk           (clk),
    .reset         (reset),
    .cycle_en      (cycle_en),
    .instret_en    (instret_en),
    .cycle_count   (bus.cycle_count),
    .instret_count (bus.instret_count)
  );
`else
  assign bus.cycle_count   = '0;
  assign bus.instret_count = '0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - self-checking bench for mc_control_fsm (honours MC_CTRL_PERF_CNT_EN)
module tb_mc_control_fsm;

  localparam logic [6:0] T_LOAD  = 7'b0000011;
  localparam logic [6:0] T_STORE = 7'b0100011;
  localparam logic [6:0] T_BR    = 7'b1100011;
  localparam logic [6:0] T_JAL   = 7'b1101111;
  localparam logic [6:0] T_JALR  = 7'b1100111;
  localparam logic [6:0] T_ALU   = 7'b0110011;
  localparam logic [6:0] T_ALUI  = 7'b0010011;
  localparam logic [6:0] T_SYS   = 7'b1110011;
  localparam logic [6:0] T_BAD   = 7'b1111111;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
  } tctl_t;

  typedef struct {
    logic [6:0] opc;
    bit         bcond;
    bit         halt;
    int         wif;
    int         wmem;
    int         exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_ctrl_if #(.INST_W(32)) bus();
  mc_control_fsm #(.INST_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad = 0;
  logic [31:0] cyc_m = '0;
  logic [31:0] ret_m = '0;
  tctl_t plan_w[$];
  int    plan_m[$];
  bit    plan_l[$];

  function automatic tctl_t got();
    tctl_t g;
    g.pc_write  = bus.pc_write;
    g.pc_source = bus.pc_source;
    g.i_or_d    = bus.i_or_d;
    g.mem_read  = bus.mem_read;
    g.mem_write = bus.mem_write;
    g.ir_write  = bus.ir_write;
    g.reg_write = bus.reg_write;
    g.wb_sel    = bus.wb_sel;
    g.alu_src_a = bus.alu_src_a;
    g.alu_src_b = bus.alu_src_b;
    g.alu_op    = bus.alu_op;
    g.halted    = bus.halted;
    return g;
  endfunction

  function automatic tctl_t w_reset();
    tctl_t c = '0;
    c.mem_read = 1'b1;
    return c;
  endfunction

  // Per-cycle compare of all controls and both counters, then advance one clock.
  task automatic step(input tctl_t exp, input bit last, input string nm, output tctl_t g);
    logic [31:0] ecyc, eret;
    @(negedge clk);
    g = got();
`ifdef MC_CTRL_PERF_CNT_EN
    ecyc = cyc_m;
    eret = ret_m;
`else
    ecyc = '0;
    eret = '0;
`endif
    total++;
    if (g !== exp) begin
      bad++;
      $display("FAIL %s: ctl got %h want %h", nm, g, exp);
    end
    total++;
    if (bus.cycle_count !== ecyc || bus.instret_count !== eret) begin
      bad++;
      $display("FAIL %s counters: got %0d/%0d want %0d/%0d", nm,
               bus.cycle_count, bus.instret_count, ecyc, eret);
    end
    @(posedge clk);
    if (reset) begin
      cyc_m = '0;
      ret_m = '0;
    end else begin
      if (!exp.halted) cyc_m = cyc_m + 32'd1;
      if (last) ret_m = ret_m + 32'd1;
    end
    #1;
  endtask

  task automatic push(input tctl_t w, input int m, input bit l);
    plan_w.push_back(w);
    plan_m.push_back(m);
    plan_l.push_back(l);
  endtask

  // Expected control sequence of one instruction with memory always ready (1=fetch wait, 2=data wait).
  task automatic build_plan(input logic [6:0] opc, input bit bcond, input bit halt);
    tctl_t f, d, x, m, w;
    plan_w.delete(); plan_m.delete(); plan_l.delete();
    f = '0; f.mem_read = 1; f.ir_write = 1;
    push(f, 1, 0);
    d = '0; d.alu_src_b = 2'd1;
    x = '0; x.alu_src_a = 1;
    if (opc == T_SYS && halt) begin
      push(d, 0, 1);
      x = '0; x.halted = 1;
      for (int i = 0; i < 3; i++) push(x, 0, 1);
    end else if (opc == T_SYS || !(opc inside {T_LOAD, T_STORE, T_BR, T_JAL, T_JALR, T_ALU, T_ALUI})) begin
      d.pc_write = 1; d.pc_source = 2'd2;
      push(d, 0, 1);
    end else begin
      push(d, 0, 0);
      w = '0; w.reg_write = 1; w.pc_write = 1; w.pc_source = 2'd2;
      m = '0; m.i_or_d = 1;
      case (opc)
        T_ALU, T_ALUI: begin
          x.alu_src_b = (opc == T_ALU) ? 2'd0 : 2'd1; x.alu_op = 2'd2;
          push(x, 0, 0); push(w, 0, 1);
        end
        T_LOAD: begin
          x.alu_src_b = 2'd1; push(x, 0, 0);
          m.mem_read = 1; push(m, 2, 0);
          w.wb_sel = 2'd1; push(w, 0, 1);
        end
        T_STORE: begin
          x.alu_src_b = 2'd1; push(x, 0, 0);
          m.mem_write = 1; m.pc_write = 1; m.pc_source = 2'd2; push(m, 2, 1);
        end
        T_BR: begin
          x.alu_op = 2'd1; x.pc_write = 1; x.pc_source = bcond ? 2'd1 : 2'd2;
          push(x, 0, 1);
        end
        T_JAL: begin
          x = '0; x.reg_write = 1; x.wb_sel = 2'd2; x.pc_write = 1; x.pc_source = 2'd1;
          push(x, 0, 1);
        end
        default: begin
          x.alu_src_b = 2'd1; x.reg_write = 1; x.wb_sel = 2'd2; x.pc_write = 1; x.pc_source = 2'd0;
          push(x, 0, 1);
        end
      endcase
    end
  endtask

  // Runs one instruction; lat/exp_lat = cycle of first PC write or halt as seen on the DUT/model.
  task automatic run_instr(input logic [6:0] opc, input bit bcond, input bit halt,
                           input int wif, input int wmem, output int lat, output int exp_lat);
    logic [31:0] r;
    tctl_t g, e;
    int n, cyc;
    r = $urandom();
    bus.inst = {r[31:7], opc};
    bus.bcond = bcond;
    build_plan(opc, bcond, halt);
    lat = 0; exp_lat = 0; cyc = 0;
    for (int i = 0; i < plan_w.size(); i++) begin
      n = (plan_m[i] == 1) ? wif : (plan_m[i] == 2) ? wmem : 0;
      for (int k = 0; k < n; k++) begin
        e = plan_w[i]; e.ir_write = 0; e.pc_write = 0; e.pc_source = 2'd0;
        bus.mem_ready = 1'b0;
        bus.halt_req = 1'($urandom());
        cyc++;
        step(e, 1'b0, "wait", g);
        if (lat == 0 && (g.pc_write || g.halted)) lat = cyc;
      end
      bus.mem_ready = (plan_m[i] != 0) ? 1'b1 : 1'($urandom());
      bus.halt_req = (i == 1) ? halt : 1'($urandom());
      cyc++;
      step(plan_w[i], plan_l[i], "step", g);
      if (lat == 0 && (g.pc_write || g.halted)) lat = cyc;
      if (exp_lat == 0 && (plan_w[i].pc_write || plan_w[i].halted)) exp_lat = cyc;
    end
    if (halt && opc == T_SYS) begin
      reset = 1'b1;
      step(w_reset(), 1'b0, "halt_reset", g);
      reset = 1'b0;
    end
  endtask

  initial begin
    vec_t vt[$];
    tctl_t g;
    int lat, elat;
    logic [6:0] ops [9];

    vt.push_back('{T_ALU,   0, 0, 0, 0, 4});
    vt.push_back('{T_LOAD,  0, 0, 0, 3, 8});
    vt.push_back('{T_STORE, 0, 0, 0, 0, 4});
    vt.push_back('{T_BR,    1, 0, 0, 0, 3});
    vt.push_back('{T_BR,    0, 0, 0, 0, 3});
    vt.push_back('{T_JAL,   0, 0, 0, 0, 3});
    vt.push_back('{T_JALR,  0, 0, 0, 0, 3});
    vt.push_back('{T_ALUI,  0, 0, 2, 0, 6});
    vt.push_back('{T_LOAD,  0, 0, 0, 0, 5});
    vt.push_back('{T_SYS,   0, 0, 0, 0, 2});
    vt.push_back('{T_BAD,   0, 0, 1, 0, 3});
    vt.push_back('{T_SYS,   0, 1, 0, 0, 3});

    reset = 1'b1;
    bus.inst = 32'h0000_0013;
    bus.mem_ready = 1'b1;
    bus.bcond = 1'b0;
    bus.halt_req = 1'b0;
    @(posedge clk); #1;
    step(w_reset(), 1'b0, "reset0", g);
    step(w_reset(), 1'b0, "reset1", g);
    reset = 1'b0;

    foreach (vt[i]) begin
      run_instr(vt[i].opc, vt[i].bcond, vt[i].halt, vt[i].wif, vt[i].wmem, lat, elat);
      total++;
      if (lat !== vt[i].exp_lat) begin
        bad++;
        $display("FAIL latency vec%0d: got %0d want %0d", i, lat, vt[i].exp_lat);
      end
    end

    // Reset while a store is completing in MEM must not let its writes through.
    bus.inst = {25'h1, T_STORE};
    build_plan(T_STORE, 1'b0, 1'b0);
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) step(plan_w[i], plan_l[i], "st_pre", g);
    reset = 1'b1;
    step(w_reset(), 1'b0, "st_reset", g);
    reset = 1'b0;
    run_instr(T_ALU, 1'b0, 1'b0, 0, 0, lat, elat);

    ops = '{T_LOAD, T_STORE, T_BR, T_JAL, T_JALR, T_ALU, T_ALUI, T_SYS, T_BAD};
    for (int n = 0; n < 150; n++) begin
      logic [6:0] opc;
      bit h;
      opc = ops[$urandom_range(0, 8)];
      h = (opc == T_SYS) && ($urandom_range(0, 3) == 0);
      run_instr(opc, 1'($urandom()), h, $urandom_range(0, 3), $urandom_range(0, 3), lat, elat);
      total++;
      if (lat !== elat) begin
        bad++;
        $display("FAIL rand latency %0d op %b: got %0d want %0d", n, opc, lat, elat);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
